// File: rtl/mem_dma.sv
// Block-transfer engine owning the data-memory port: CPU pass-through when idle, COPY/FILL/SUM when started.
// Latency (start edge to done cycle): COPY 2*len+1, FILL len+1, SUM len+1, len=0 or reserved mode 1.
// Backpressure: none on the memory side; cpu_stall (== busy) holds the CPU for the whole operation.
// Ports: clk/rst; command start/mode/src/dst/len/fill_val; status busy/done/err/sum_out/sum_ovf;
//        CPU side cpu_wr/cpu_addr/cpu_data_in/cpu_stall; memory side mem_wr/mem_addr/mem_data_in/mem_data_out.
module mem_dma #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] sum_out,
  output logic          sum_ovf,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_data_in,
  output logic          cpu_stall,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_FILL = 3'd3,
    S_ACC  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] src_ptr_q, src_ptr_d;
  logic [AW-1:0] dst_ptr_q, dst_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] buf_q, buf_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] sum_out_q, sum_out_d;
  logic          sum_ovf_q, sum_ovf_d;
  logic          err_q, err_d;
  logic [DW-1:0] acc_sum;
  logic          acc_ovf;

  // Signed overflow: operands agree in sign but the wrapped result does not.
  assign acc_sum = acc_q + mem_data_out;
  assign acc_ovf = (acc_q[DW-1] == mem_data_out[DW-1]) && (acc_sum[DW-1] != acc_q[DW-1]);

  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    fill_d      = fill_q;
    acc_d       = acc_q;
    sum_out_d   = sum_out_q;
    sum_ovf_d   = sum_ovf_q;
    err_d       = err_q;
    busy        = 1'b1;
    done        = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = cpu_addr;
    mem_data_in = cpu_data_in;

    case (state_q)
      S_IDLE: begin
        busy   = 1'b0;
        mem_wr = cpu_wr;
        if (start) begin
          src_ptr_d = src;
          dst_ptr_d = dst;
          cnt_d     = len;
          fill_d    = fill_val;
          err_d     = (mode == 2'd3);
          if (mode == 2'd2) begin
            acc_d     = '0;
            sum_ovf_d = 1'b0;
            // An empty SUM still counts as a SUM: its result is zero.
            if (len == '0) sum_out_d = '0;
          end
          if (len == '0 || mode == 2'd3) state_d = S_DONE;
          else if (mode == 2'd0)         state_d = S_RD;
          else if (mode == 2'd1)         state_d = S_FILL;
          else                           state_d = S_ACC;
        end
      end
      S_RD: begin
        mem_addr  = src_ptr_q;
        buf_d     = mem_data_out;
        src_ptr_d = src_ptr_q + PTR_ONE;
        state_d   = S_WR;
      end
      S_WR: begin
        mem_wr      = 1'b1;
        mem_addr    = dst_ptr_q;
        mem_data_in = buf_q;
        dst_ptr_d   = dst_ptr_q + PTR_ONE;
        cnt_d       = cnt_q - CNT_ONE;
        state_d     = (cnt_q == CNT_ONE) ? S_DONE : S_RD;
      end
      S_FILL: begin
        mem_wr      = 1'b1;
        mem_addr    = dst_ptr_q;
        mem_data_in = fill_q;
        dst_ptr_d   = dst_ptr_q + PTR_ONE;
        cnt_d       = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_DONE;
      end
      S_ACC: begin
        mem_addr  = src_ptr_q;
        acc_d     = acc_sum;
        sum_ovf_d = sum_ovf_q | acc_ovf;
        src_ptr_d = src_ptr_q + PTR_ONE;
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          sum_out_d = acc_sum;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        // Address/data follow the CPU again, but no write is issued this cycle.
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      fill_q    <= '0;
      acc_q     <= '0;
      sum_out_q <= '0;
      sum_ovf_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      fill_q    <= fill_d;
      acc_q     <= acc_d;
      sum_out_q <= sum_out_d;
      sum_ovf_q <= sum_ovf_d;
      err_q     <= err_d;
    end
  end

  assign err       = done & err_q;
  assign sum_out   = sum_out_q;
  assign sum_ovf   = sum_ovf_q;
  assign cpu_stall = busy;

endmodule

// File: doc/mem_dma.md
Name: mem_dma

Overview:
- Block-transfer engine that sits directly upstream of the data memory and owns its single read/write port.
- While idle, it passes CPU accesses straight through to the memory.
- When started, it sequences one of three operations over a contiguous address range: COPY (memory to memory), FILL (constant to memory) or SUM (signed accumulate of memory words).
- It stalls the CPU for the duration of the operation.

Parameters:
- AW, 8, memory address width; range arithmetic is modulo 2^AW.
- DW, 32, data word width (signed).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  2  operation: 0=COPY, 1=FILL, 2=SUM, 3=reserved.
- src  in  AW  source start address (COPY, SUM).
- dst  in  AW  destination start address (COPY, FILL).
- len  in  AW+1  word count, 0..256.
- fill_val  in  DW  signed fill constant (FILL).
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  reserved mode; valid while done=1.
- sum_out  out  DW  signed SUM result; holds until the next SUM start.
- sum_ovf  out  1  sticky signed overflow during the last SUM.
- cpu_wr  in  1  CPU write enable.
- cpu_addr  in  AW  CPU address.
- cpu_data_in  in  DW  CPU write data.
- cpu_stall  out  1  equals busy; CPU must hold its request while high.
- mem_wr  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_data_in  out  DW  memory write data.
- mem_data_out  in  DW  memory read data; combinational from mem_addr, same cycle.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, err=0, sum_out=0, sum_ovf=0, src_ptr=dst_ptr=0, cnt=0, buf=0.
- Reset mid-operation aborts immediately. No memory write occurs after rst asserts, and the remaining words are left untouched.
- States: IDLE, RD, WR, FILL, ACC, DONE.
- IDLE:
  - mem_wr=cpu_wr, mem_addr=cpu_addr, mem_data_in=cpu_data_in (combinational pass-through).
  - busy=0.
- start=1 in IDLE, captured at the posedge:
  - Latch src_ptr, dst_ptr, cnt=len, fill value and mode.
  - len=0 or mode=3: go to DONE; no memory access; err=1 for mode 3.
  - COPY: go to RD.
  - FILL: go to FILL.
  - SUM: go to ACC; clear the accumulator and sum_ovf at this edge.
- start while not in IDLE is ignored. There is no queuing.
- In every state except IDLE, busy=1 and the CPU inputs are ignored (cpu_wr never reaches memory).
- RD: mem_wr=0, mem_addr=src_ptr. At posedge: buf<=mem_data_out, src_ptr++, go to WR.
- WR:
  - mem_wr=1, mem_addr=dst_ptr, mem_data_in=buf.
  - At posedge: dst_ptr++, cnt--; go to DONE if cnt was 1, else RD.
- FILL:
  - mem_wr=1, mem_addr=dst_ptr, mem_data_in=fill value.
  - At posedge: dst_ptr++, cnt--; go to DONE if cnt was 1, else stay.
- ACC:
  - mem_wr=0, mem_addr=src_ptr.
  - At posedge: acc<=acc+mem_data_out, wrapping modulo 2^DW.
  - sum_ovf set if both operands have the same sign and the result sign differs.
  - src_ptr++, cnt--; go to DONE if cnt was 1.
  - sum_out updates when entering DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle; memory port back to pass-through.
  - Next state IDLE; a start in DONE is ignored.
- Latency, start edge to done cycle: COPY 2*len+1 cycles, FILL len+1, SUM len+1, len=0 gives 1.
- Pointer wrap: 255+1 -> 0, silently. len=256 touches every address exactly once.
- Overlap: COPY is strictly ascending and word-by-word. With dst in (src, src+len), copied words propagate (defined behaviour, not an error).
- mem_wr is asserted only in WR, FILL or pass-through. It is never asserted in RD, ACC or DONE.

Test Plan:
- Reset/pass-through: rst pulse, then CPU writes 0x1234 to address 5 and reads it back -> mem[5]=0x1234; busy=0 throughout.
- COPY: mem[10..13]={1,-2,3,-4}; start with mode=0, src=10, dst=40, len=4.
  - mem[40..43]={1,-2,3,-4}.
  - busy high for 8 cycles; done pulses at cycle 9.
  - A CPU write to addr 41 attempted during busy is dropped.
- FILL wrap: mode=1, dst=254, fill_val=-1, len=4 -> mem[254], mem[255], mem[0], mem[1] = 0xFFFFFFFF; mem[2] unchanged; done at cycle 5.
- SUM overflow: mem[0]=0x7FFFFFFF, mem[1]=1, mem[2]=5; mode=2, src=0, len=3 -> sum_out=0x80000005, sum_ovf=1.
  - A following SUM over mem[2] alone gives sum_out=5, sum_ovf=0.
- Edge commands:
  - len=0 (mode 0) -> done next cycle, err=0, no mem_wr.
  - mode=3 with len=7 -> done next cycle with err=1.
  - start held high for 5 cycles -> only one operation runs.
- Reset mid-COPY: src=0, dst=100, len=10; assert rst during the third WR cycle -> only mem[100], mem[101] written; busy=0, sum_out=0 after reset.
